// File: rtl/l2_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : l2_fill_engine
// Brief    : Round-robin miss arbiter feeding a single-outstanding cache fill
//            sequencer (IDLE -> READ -> WAIT -> FILL). Requests for the same
//            block as the winner are coalesced into one fill.
// Revision : 1.0 - initial release
// ============================================================================
module l2_fill_engine #(
  parameter int PORTS       = 4,
  parameter int CACHE_SIZE  = 16,
  parameter int MEM_LATENCY = 2,
  parameter int COORD_W     = 8,
  parameter int BLOCK_W     = 8,
  parameter logic [BLOCK_W-1:0] BLOCK_AIR = '0,
  localparam int c_pos_w = 3 * COORD_W,
  localparam int c_idx_w = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [PORTS-1:0]           miss_req,
  input  logic [PORTS*c_pos_w-1:0]   miss_addr,
  output logic [PORTS-1:0]           miss_ack,
  output logic                       mem_rd,
  output logic [c_pos_w-1:0]         mem_addr,
  input  logic [BLOCK_W-1:0]         mem_data,
  output logic                       fill_we,
  output logic [c_idx_w-1:0]         fill_idx,
  output logic [c_pos_w-1:0]         fill_tag,
  output logic [BLOCK_W-1:0]         fill_data,
  output logic                       busy
);

  localparam int c_port_w = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int c_cnt_w  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [c_port_w:0]   c_ports     = (c_port_w+1)'(PORTS);
  localparam logic [c_port_w-1:0] c_last_port = c_port_w'(PORTS - 1);
  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(CACHE_SIZE - 1);
  localparam logic [c_cnt_w-1:0]  c_last_cnt  = c_cnt_w'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_port_w-1:0]  r_rr_ptr, w_rr_ptr_nxt, w_winner;
  logic [c_port_w:0]    w_sum;
  logic                 w_found;
  logic [c_pos_w-1:0]   w_win_addr;
  logic [PORTS-1:0]     w_match;
  logic [c_idx_w-1:0]   r_repl_ptr, w_repl_ptr_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [PORTS-1:0]     r_miss_ack, w_miss_ack_nxt;
  logic                 r_mem_rd, w_mem_rd_nxt;
  logic [c_pos_w-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                 r_fill_we, w_fill_we_nxt;
  logic [c_idx_w-1:0]   r_fill_idx, w_fill_idx_nxt;
  logic [c_pos_w-1:0]   r_fill_tag, w_fill_tag_nxt;
  logic [BLOCK_W-1:0]   r_fill_data, w_fill_data_nxt;

  // Round-robin search: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_port_w+1)'(i);
      if (w_sum >= c_ports) w_sum = w_sum - c_ports;
      if (!w_found && miss_req[w_sum[c_port_w-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[c_port_w-1:0];
      end
    end
  end

  // Winner address and the set of ports asking for that same block.
  always_comb begin
    w_win_addr = '0;
    w_match    = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (c_port_w'(i) == w_winner) w_win_addr = miss_addr[i*c_pos_w +: c_pos_w];
    end
    for (int i = 0; i < PORTS; i++) begin
      w_match[i] = miss_req[i] && (miss_addr[i*c_pos_w +: c_pos_w] == w_win_addr);
    end
  end

  // Next-state and next registered-output logic; strobes default low.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_repl_ptr_nxt  = r_repl_ptr;
    w_cnt_nxt       = r_cnt;
    w_miss_ack_nxt  = '0;
    w_mem_rd_nxt    = 1'b0;
    w_fill_we_nxt   = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_fill_idx_nxt  = r_fill_idx;
    w_fill_tag_nxt  = r_fill_tag;
    w_fill_data_nxt = r_fill_data;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_READ;
          w_miss_ack_nxt = w_match;
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = w_win_addr;
          w_rr_ptr_nxt   = (w_winner == c_last_port) ? '0 : w_winner + 1'b1;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        // Last WAIT cycle is exactly when the memory presents the block.
        if (r_cnt == c_last_cnt) begin
          w_state_nxt     = ST_FILL;
          w_fill_we_nxt   = 1'b1;
          w_fill_idx_nxt  = r_repl_ptr;
          w_fill_tag_nxt  = r_mem_addr;
          w_fill_data_nxt = mem_data;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_FILL: begin
        w_state_nxt    = ST_IDLE;
        w_repl_ptr_nxt = (r_repl_ptr == c_last_idx) ? '0 : r_repl_ptr + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any fill in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_repl_ptr  <= '0;
      r_cnt       <= '0;
      r_miss_ack  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_fill_we   <= 1'b0;
      r_fill_idx  <= '0;
      r_fill_tag  <= '0;
      r_fill_data <= BLOCK_AIR;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_repl_ptr  <= w_repl_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_miss_ack  <= w_miss_ack_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_fill_we   <= w_fill_we_nxt;
      r_fill_idx  <= w_fill_idx_nxt;
      r_fill_tag  <= w_fill_tag_nxt;
      r_fill_data <= w_fill_data_nxt;
    end
  end

  assign miss_ack  = r_miss_ack;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign fill_we   = r_fill_we;
  assign fill_idx  = r_fill_idx;
  assign fill_tag  = r_fill_tag;
  assign fill_data = r_fill_data;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l2_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_fill_engine
// Brief    : Self-checking bench for l2_fill_engine: vector table, directed
//            multi-cycle sequences and a randomized run against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_fill_engine;

  localparam int PORTS       = 4;
  localparam int CACHE_SIZE  = 16;
  localparam int MEM_LATENCY = 2;
  localparam int COORD_W     = 8;
  localparam int BLOCK_W     = 8;
  localparam int POS_W       = 3 * COORD_W;
  localparam int NRAND       = 1500;
  localparam int NARR        = NRAND + 16;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [PORTS-1:0]         miss_req;
  logic [PORTS*POS_W-1:0]   miss_addr;
  logic [PORTS-1:0]         miss_ack;
  logic                     mem_rd;
  logic [POS_W-1:0]         mem_addr;
  logic [BLOCK_W-1:0]       mem_data;
  logic                     fill_we;
  logic [3:0]               fill_idx;
  logic [POS_W-1:0]         fill_tag;
  logic [BLOCK_W-1:0]       fill_data;
  logic                     busy;

  l2_fill_engine #(
    .PORTS(PORTS), .CACHE_SIZE(CACHE_SIZE), .MEM_LATENCY(MEM_LATENCY),
    .COORD_W(COORD_W), .BLOCK_W(BLOCK_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_tag(fill_tag),
    .fill_data(fill_data), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [POS_W-1:0] pos(input int x, input int y, input int z);
    return {COORD_W'(x), COORD_W'(y), COORD_W'(z)};
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},       64'(miss_ack),  64'd0);
    chk({tag, "_mem_rd"},    64'(mem_rd),    64'd0);
    chk({tag, "_fill_we"},   64'(fill_we),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_fill_idx"},  64'(fill_idx),  64'd0);
    chk({tag, "_fill_tag"},  64'(fill_tag),  64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_fill_data"}, 64'(fill_data), 64'd0);
  endtask

  // Leaves rst_in low at a negedge: the caller's inputs form the first cycle.
  task automatic do_reset();
    rst_in   = 1'b1;
    miss_req = '0;
    mem_data = '0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_in = 1'b0;
  endtask

  // Called at the negedge of grant cycle T with requests already applied.
  // Returns at the negedge of T+3+MEM_LATENCY (engine idle again).
  task automatic run_fill(input logic [PORTS-1:0] exp_ack, input logic [POS_W-1:0] exp_tag,
                          input logic [3:0] exp_idx, input logic [BLOCK_W-1:0] data,
                          input logic [PORTS-1:0] drop_mask, input logic [PORTS-1:0] late_mask);
    tick();
    chk("grant_ack",      64'(miss_ack), 64'(exp_ack));
    chk("grant_mem_rd",   64'(mem_rd),   64'd1);
    chk("grant_mem_addr", 64'(mem_addr), 64'(exp_tag));
    chk("grant_busy",     64'(busy),     64'd1);
    chk("grant_fill_we",  64'(fill_we),  64'd0);
    miss_req = miss_req & ~drop_mask;
    mem_data = ~data;
    for (int t = 2; t <= MEM_LATENCY + 2; t++) begin
      tick();
      chk("flight_ack",    64'(miss_ack), 64'd0);
      chk("flight_mem_rd", 64'(mem_rd),   64'd0);
      chk("flight_busy",   64'(busy),     64'd1);
      if (t < MEM_LATENCY + 2) begin
        chk("wait_fill_we", 64'(fill_we), 64'd0);
      end else begin
        chk("fill_we",   64'(fill_we),   64'd1);
        chk("fill_idx",  64'(fill_idx),  64'(exp_idx));
        chk("fill_tag",  64'(fill_tag),  64'(exp_tag));
        chk("fill_data", 64'(fill_data), 64'(data));
      end
      if (t == 2) miss_req = miss_req | late_mask;
      mem_data = (t == MEM_LATENCY + 1) ? data : ~data;
    end
    tick();
    chk("idle_busy",    64'(busy),     64'd0);
    chk("idle_fill_we", 64'(fill_we),  64'd0);
    chk("idle_ack",     64'(miss_ack), 64'd0);
    chk("idle_mem_rd",  64'(mem_rd),   64'd0);
  endtask

  typedef struct {
    logic [PORTS-1:0]       req;
    logic [PORTS*POS_W-1:0] addr;
    logic [PORTS-1:0]       exp_ack;
    logic [POS_W-1:0]       exp_tag;
    logic [3:0]             exp_idx;
  } vec_t;

  vec_t vecs[8];
  logic [POS_W-1:0] pa, pc, pd, pe, pf, pg, ph, pz;
  logic [POS_W-1:0] held[PORTS];
  logic [POS_W-1:0] pool[4];

  // Reference model state and per-cycle expectation tables.
  int               m_rr, m_repl, free_at, w;
  logic [POS_W-1:0] waddr;
  logic [PORTS-1:0] wmask;
  logic [PORTS-1:0] e_ack [NARR];
  logic             e_rd  [NARR];
  logic             e_we  [NARR];
  logic             e_busy[NARR];
  logic [POS_W-1:0] e_addr[NARR];
  logic [POS_W-1:0] e_tag [NARR];
  int               e_idx [NARR];
  int               e_src [NARR];
  logic [BLOCK_W-1:0] md  [NARR];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_in    = 1'b1;
    miss_req  = '0;
    miss_addr = '0;
    mem_data  = '0;

    pa = pos(3, -2, 5);  pc = pos(1, 1, 1);   pd = pos(-4, 7, 0);  pe = pos(9, -9, 2);
    pf = pos(0, 5, -1);  pg = pos(-8, -8, 8); ph = pos(6, 0, -3);  pz = pos(0, 0, 0);

    // Expected winners follow the round-robin pointer carried between rows.
    vecs[0] = '{4'b0010, {pz, pz, pa, pz}, 4'b0010, pa, 4'd0};
    vecs[1] = '{4'b1001, {pc, pd, pe, pc}, 4'b1001, pc, 4'd1};
    vecs[2] = '{4'b1111, {pf, pg, ph, pd}, 4'b0001, pd, 4'd2};
    vecs[3] = '{4'b1100, {pe, pe, pf, pg}, 4'b1100, pe, 4'd3};
    vecs[4] = '{4'b0111, {pe, pf, pg, ph}, 4'b0001, ph, 4'd4};
    vecs[5] = '{4'b0011, {pd, pe, pf, pf}, 4'b0011, pf, 4'd5};
    vecs[6] = '{4'b1000, {pg, pz, pz, pz}, 4'b1000, pg, 4'd6};
    vecs[7] = '{4'b0110, {ph, pg, pg, ph}, 4'b0110, pg, 4'd7};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      miss_addr = vecs[i].addr;
      miss_req  = vecs[i].req;
      run_fill(vecs[i].exp_ack, vecs[i].exp_tag, vecs[i].exp_idx,
               BLOCK_W'(8'h30 + i), '1, '0);
    end

    // Round-robin with two held requests: port 2 waits a full fill.
    do_reset();
    miss_addr = {pz, pd, pz, pe};
    miss_req  = 4'b0101;
    run_fill(4'b0001, pe, 4'd0, 8'h51, 4'b0001, '0);
    run_fill(4'b0100, pd, 4'd1, 8'h52, 4'b0100, '0);

    // Request arriving during WAIT is not acked until after IDLE returns.
    miss_addr = {pz, pf, pz, pc};
    miss_req  = 4'b0001;
    run_fill(4'b0001, pc, 4'd2, 8'h61, 4'b0001, 4'b0100);
    run_fill(4'b0100, pf, 4'd3, 8'h62, 4'b0100, '0);

    // Reset in WAIT abandons the fill; held request re-granted from scratch.
    do_reset();
    miss_addr = {pz, pz, pa, pz};
    miss_req  = 4'b0010;
    tick();
    chk("rst_wait_ack", 64'(miss_ack), 64'(4'b0010));
    chk("rst_wait_rd",  64'(mem_rd),   64'd1);
    tick();
    chk("rst_wait_busy", 64'(busy), 64'd1);
    rst_in   = 1'b1;
    mem_data = 8'hEE;
    tick();
    chk_reset_outputs("rst_mid");
    rst_in = 1'b0;
    run_fill(4'b0010, pa, 4'd0, 8'h71, 4'b0010, '0);

    // Seventeen fills with every port held: rr and replacement both wrap.
    do_reset();
    for (int p = 0; p < PORTS; p++) begin
      held[p] = pos(p, 10 + p, -p);
      miss_addr[p*POS_W +: POS_W] = held[p];
    end
    miss_req = '1;
    for (int i = 0; i < 17; i++) begin
      run_fill(PORTS'(1 << (i % PORTS)), held[i % PORTS], 4'(i % CACHE_SIZE),
               BLOCK_W'(8'h80 + i), '0, '0);
    end

    // Randomized traffic against the transaction-level model.
    do_reset();
    miss_addr = '0;
    pool[0] = pa; pool[1] = pc; pool[2] = pos(-1, -1, -1); pool[3] = pos(127, -128, 4);
    for (int k = 0; k < NARR; k++) begin
      e_ack[k] = '0; e_rd[k] = 1'b0; e_we[k] = 1'b0; e_busy[k] = 1'b0;
      e_addr[k] = '0; e_tag[k] = '0; e_idx[k] = 0; e_src[k] = 0; md[k] = '0;
    end
    m_rr = 0; m_repl = 0; free_at = 0;
    for (int k = 0; k < NRAND; k++) begin
      chk("rnd_ack",     64'(miss_ack), 64'(e_ack[k]));
      chk("rnd_mem_rd",  64'(mem_rd),   64'(e_rd[k]));
      chk("rnd_fill_we", 64'(fill_we),  64'(e_we[k]));
      chk("rnd_busy",    64'(busy),     64'(e_busy[k]));
      if (e_rd[k]) chk("rnd_mem_addr", 64'(mem_addr), 64'(e_addr[k]));
      if (e_we[k]) begin
        chk("rnd_fill_idx",  64'(fill_idx),  64'(e_idx[k]));
        chk("rnd_fill_tag",  64'(fill_tag),  64'(e_tag[k]));
        chk("rnd_fill_data", 64'(fill_data), 64'(md[e_src[k]]));
      end
      for (int p = 0; p < PORTS; p++) begin
        if (e_ack[k][p]) begin
          miss_req[p] = 1'b0;
        end else if (miss_req[p]) begin
          if ($urandom_range(0, 39) == 0) miss_req[p] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          miss_req[p] = 1'b1;
          miss_addr[p*POS_W +: POS_W] = pool[$urandom_range(0, 3)];
        end
      end
      md[k]    = BLOCK_W'($urandom);
      mem_data = md[k];
      if (k >= free_at && miss_req != '0) begin
        w = -1;
        for (int i = 0; i < PORTS; i++) begin
          if (w < 0 && miss_req[(m_rr + i) % PORTS]) w = (m_rr + i) % PORTS;
        end
        waddr = miss_addr[w*POS_W +: POS_W];
        for (int p = 0; p < PORTS; p++) begin
          wmask[p] = miss_req[p] && (miss_addr[p*POS_W +: POS_W] == waddr);
        end
        e_ack[k+1]  = wmask;
        e_rd[k+1]   = 1'b1;
        e_addr[k+1] = waddr;
        for (int j = k + 1; j <= k + 2 + MEM_LATENCY; j++) e_busy[j] = 1'b1;
        e_we [k+2+MEM_LATENCY] = 1'b1;
        e_idx[k+2+MEM_LATENCY] = m_repl;
        e_tag[k+2+MEM_LATENCY] = waddr;
        e_src[k+2+MEM_LATENCY] = k + 1 + MEM_LATENCY;
        m_rr    = (w + 1) % PORTS;
        m_repl  = (m_repl + 1) % CACHE_SIZE;
        free_at = k + 3 + MEM_LATENCY;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
